// File: rtl/assoc_wb_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assoc_wb_cache_pkg: shared state encoding and default geometry        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package assoc_wb_cache_pkg;

  localparam int c_DEF_ADDR_W         = 16;
  localparam int c_DEF_DATA_W         = 16;
  localparam int c_DEF_WORDS_PER_LINE = 4;
  localparam int c_DEF_SETS           = 8;
  localparam int c_DEF_WAYS           = 2;
  localparam int c_DEF_CNT_W          = 16;

  localparam int c_DEF_OFF_W   = $clog2(c_DEF_WORDS_PER_LINE);
  localparam int c_DEF_INDEX_W = $clog2(c_DEF_SETS);
  localparam int c_DEF_TAG_W   = c_DEF_ADDR_W - c_DEF_OFF_W - c_DEF_INDEX_W;
  localparam int c_DEF_LINE_W  = c_DEF_DATA_W * c_DEF_WORDS_PER_LINE;
  localparam int c_DEF_MADDR_W = c_DEF_ADDR_W - c_DEF_OFF_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/assoc_wb_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assoc_wb_cache_if: processor request port and line-memory handshake   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface assoc_wb_cache_if
  import assoc_wb_cache_pkg::*;
#(
  parameter int ADDR_W         = c_DEF_ADDR_W,
  parameter int DATA_W         = c_DEF_DATA_W,
  parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
  parameter int CNT_W          = c_DEF_CNT_W
);
  localparam int c_MADDR_W = ADDR_W - $clog2(WORDS_PER_LINE);
  localparam int c_LINE_W  = DATA_W * WORDS_PER_LINE;

  logic                 enable;
  logic                 rd_wrt;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    rdata;
  logic                 idle;
  logic                 done;
  logic                 mem_req;
  logic                 mem_we;
  logic [c_MADDR_W-1:0] mem_addr;
  logic [c_LINE_W-1:0]  mem_wdata;
  logic [c_LINE_W-1:0]  mem_rdata;
  logic                 mem_rdy;
  logic [CNT_W-1:0]     hit_cnt;
  logic [CNT_W-1:0]     miss_cnt;

  // master = processor/memory environment, slave = the cache
  modport master (
    output enable, rd_wrt, addr, wdata, mem_rdata, mem_rdy,
    input  rdata, idle, done, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport slave (
    input  enable, rd_wrt, addr, wdata, mem_rdata, mem_rdy,
    output rdata, idle, done, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/assoc_wb_cache_way_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_way_array: one way's valid/dirty/tag/line store, comb read      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cache_way_array
  import assoc_wb_cache_pkg::*;
#(
  parameter  int SETS           = c_DEF_SETS,
  parameter  int TAG_W          = c_DEF_TAG_W,
  parameter  int DATA_W         = c_DEF_DATA_W,
  parameter  int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
  localparam int INDEX_W        = $clog2(SETS),
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int LINE_W         = DATA_W * WORDS_PER_LINE
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [INDEX_W-1:0] i_index,
  input  wire logic               i_fill_en,
  input  wire logic [TAG_W-1:0]   i_fill_tag,
  input  wire logic [LINE_W-1:0]  i_fill_line,
  input  wire logic               i_word_en,
  input  wire logic [OFF_W-1:0]   i_word_off,
  input  wire logic [DATA_W-1:0]  i_word_data,
  output logic                    o_valid,
  output logic                    o_dirty,
  output logic [TAG_W-1:0]        o_tag,
  output logic [LINE_W-1:0]       o_line
);
  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_line [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_word_en) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Tag and line storage survive reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_index]  <= i_fill_tag;
      r_line[i_index] <= i_fill_line;
    end else if (i_word_en) begin
      r_line[i_index][int'(i_word_off)*DATA_W +: DATA_W] <= i_word_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_line  = r_line[i_index];
endmodule
`default_nettype wire

// File: rtl/assoc_wb_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assoc_wb_cache: set-associative write-back/write-allocate cache, FSM  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module assoc_wb_cache
  import assoc_wb_cache_pkg::*;
#(
  parameter int ADDR_W         = c_DEF_ADDR_W,
  parameter int DATA_W         = c_DEF_DATA_W,
  parameter int WORDS_PER_LINE = c_DEF_WORDS_PER_LINE,
  parameter int SETS           = c_DEF_SETS,
  parameter int WAYS           = c_DEF_WAYS,
  parameter int CNT_W          = c_DEF_CNT_W
) (
  input wire logic        clk,
  input wire logic        rst,
  assoc_wb_cache_if.slave bus
);
  localparam int c_OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int c_INDEX_W = $clog2(SETS);
  localparam int c_TAG_W   = ADDR_W - c_OFF_W - c_INDEX_W;
  localparam int c_LINE_W  = DATA_W * WORDS_PER_LINE;
  localparam int c_MADDR_W = ADDR_W - c_OFF_W;
  localparam int c_WAY_W   = $clog2(WAYS);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_rd_wrt;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_WAY_W-1:0]   r_way;
  logic                 r_adv;
  logic                 r_hit;
  logic [c_WAY_W-1:0]   r_rr [SETS];
  logic                 r_idle;
  logic                 r_done;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [c_MADDR_W-1:0] r_mem_addr;
  logic [c_LINE_W-1:0]  r_mem_wdata;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;

  logic [c_OFF_W-1:0]   w_off;
  logic [c_INDEX_W-1:0] w_index;
  logic [c_TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]      w_valid;
  logic [WAYS-1:0]      w_dirty;
  logic [c_TAG_W-1:0]   w_way_tag  [WAYS];
  logic [c_LINE_W-1:0]  w_way_line [WAYS];
  logic                 w_fill_go;
  logic                 w_word_go;
  logic                 w_hit;
  logic [c_WAY_W-1:0]   w_hit_way;
  logic                 w_inv_found;
  logic [c_WAY_W-1:0]   w_inv_way;
  logic [c_WAY_W-1:0]   w_victim;

  assign w_off     = r_addr[c_OFF_W-1:0];
  assign w_index   = r_addr[c_OFF_W +: c_INDEX_W];
  assign w_tag     = r_addr[ADDR_W-1 -: c_TAG_W];
  assign w_fill_go = (r_state == S_FILL) && r_mem_req && bus.mem_rdy;
  assign w_word_go = (r_state == S_RESPOND) && !r_rd_wrt;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(
      .SETS           (SETS),
      .TAG_W          (c_TAG_W),
      .DATA_W         (DATA_W),
      .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .i_index     (w_index),
      .i_fill_en   (w_fill_go && (r_way == c_WAY_W'(g))),
      .i_fill_tag  (w_tag),
      .i_fill_line (bus.mem_rdata),
      .i_word_en   (w_word_go && (r_way == c_WAY_W'(g))),
      .i_word_off  (w_off),
      .i_word_data (r_wdata),
      .o_valid     (w_valid[g]),
      .o_dirty     (w_dirty[g]),
      .o_tag       (w_way_tag[g]),
      .o_line      (w_way_line[g])
    );
  end

  // Victim preference: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && w_valid[w] && (w_way_tag[w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
      if (!w_inv_found && !w_valid[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = c_WAY_W'(w);
      end
    end
    w_victim = w_inv_found ? w_inv_way : r_rr[w_index];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rd_wrt    <= 1'b0;
      r_wdata     <= '0;
      r_way       <= '0;
      r_adv       <= 1'b0;
      r_hit       <= 1'b0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.enable) begin
            r_addr   <= bus.addr;
            r_rd_wrt <= bus.rd_wrt;
            r_wdata  <= bus.wdata;
            r_idle   <= 1'b0;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) begin
            r_way   <= w_hit_way;
            r_state <= S_RESPOND;
          end else begin
            r_way     <= w_victim;
            r_adv     <= !w_inv_found;
            r_mem_req <= 1'b1;
            if (w_valid[w_victim] && w_dirty[w_victim]) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_way_tag[w_victim], w_index};
              r_mem_wdata <= w_way_line[w_victim];
              r_state     <= S_WRITEBACK;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_index};
              r_state    <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_rdy) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          // After a writeback the request drops for one cycle before the fill.
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_index};
          end else if (bus.mem_rdy) begin
            r_mem_req <= 1'b0;
            if (r_adv) r_rr[w_index] <= r_way + 1'b1;
            r_state <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_done  <= 1'b1;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
          if (r_rd_wrt) r_rdata <= w_way_line[r_way][int'(w_off)*DATA_W +: DATA_W];
          if (r_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.idle      = r_idle;
  assign bus.done      = r_done;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;
endmodule
`default_nettype wire
